// File: rtl/io_input_manager.sv
// Read side of the CPU I/O space: synchronises the switches and pushbuttons, debounces the keys,
// and holds sticky press flags. Two reserved addresses return switch/key data; every other read returns SRAM data.
module io_input_manager #(
  parameter int SW_W       = 10,
  parameter int KEY_N      = 4,
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       dir_in,
  input  logic              re,
  input  logic [15:0]       sram_data,
  input  logic [SW_W-1:0]   SW,
  input  logic [KEY_N-1:0]  KEY,
  output logic [15:0]       data_out,
  output logic              io_sel
);

  localparam logic [15:0]      ADDR_KEY = 16'hFFFC;
  localparam logic [15:0]      ADDR_SW  = 16'hFFFD;
  localparam logic [DEB_W-1:0] DEB_TC   = DEB_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  sw_meta, sw_sync;
  logic [KEY_N-1:0] key_meta, key_sync;
  logic [KEY_N-1:0] key_state, key_flags;
  logic [KEY_N-1:0] key_done, key_rise;
  logic [DEB_W-1:0] cnt [KEY_N];
  logic             rd_clear;

  // Keys are inverted at the input so that 1 means pressed from here on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      key_meta <= ~KEY;
      key_sync <= key_meta;
    end
  end

  // A key is accepted on the edge where its counter sits at the terminal count and the mismatch persists.
  always_comb begin
    key_done = '0;
    key_rise = '0;
    for (int i = 0; i < KEY_N; i++) begin
      key_done[i] = (key_sync[i] != key_state[i]) && (cnt[i] == DEB_TC);
      key_rise[i] = key_done[i] && key_sync[i];
    end
  end

  assign rd_clear = re && (dir_in == ADDR_KEY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_state <= '0;
      for (int i = 0; i < KEY_N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_N; i++) begin
        if (key_sync[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (key_done[i]) begin
          key_state[i] <= key_sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // A press landing on the same edge as a clearing read survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_flags <= '0;
    else       key_flags <= (rd_clear ? '0 : key_flags) | key_rise;
  end

  always_comb begin
    data_out = sram_data;
    io_sel   = 1'b0;
    case (dir_in)
      ADDR_SW: begin
        data_out = {{(16-SW_W){1'b0}}, sw_sync};
        io_sel   = 1'b1;
      end
      ADDR_KEY: begin
        data_out = {{(16-2*KEY_N){1'b0}}, key_flags, key_state};
        io_sel   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
